// File: rtl/cache_evict_buffer_if.sv
// Handshake bundle for cache_evict_buffer: cache-side victim capture, write-beat bus and refill snoop.
// The buffer uses the slave modport; the cache/bus environment uses master.
interface cache_evict_buffer_if #(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned SETLEN  = 9,
    parameter int unsigned TAGLEN  = 20,
    parameter int unsigned LINELEN = 256,
    parameter int unsigned BEATLEN = 64
);
    localparam int unsigned OFFSETLEN = $clog2(LINELEN / 8);
    localparam int unsigned PALEN     = TAGLEN + SETLEN + OFFSETLEN;

    logic                     EvictReq;
    logic [NUMWAYS-1:0]       VictimWay;
    logic [NUMWAYS-1:0]       DirtyWay;
    logic [TAGLEN-1:0]        VictimTag;
    logic [SETLEN-1:0]        VictimSet;
    logic [LINELEN-1:0]       VictimLine;
    logic                     EvictAccept;
    logic [NUMWAYS-1:0]       ClearDirty;
    logic                     BufEmpty;

    logic                     BusValid;
    logic                     BusReady;
    logic [PALEN-1:0]         BusAdr;
    logic [BEATLEN-1:0]       BusData;
    logic                     BusLast;

    logic [TAGLEN+SETLEN-1:0] SnoopAdr;
    logic                     SnoopHit;

    modport master (
        output EvictReq, VictimWay, DirtyWay, VictimTag, VictimSet, VictimLine,
        input  EvictAccept, ClearDirty, BufEmpty,
        input  BusValid, BusAdr, BusData, BusLast,
        output BusReady,
        output SnoopAdr,
        input  SnoopHit
    );

    modport slave (
        input  EvictReq, VictimWay, DirtyWay, VictimTag, VictimSet, VictimLine,
        output EvictAccept, ClearDirty, BufEmpty,
        output BusValid, BusAdr, BusData, BusLast,
        input  BusReady,
        input  SnoopAdr,
        output SnoopHit
    );
endinterface

// File: rtl/cache_evict_buffer.sv
// Dirty-victim eviction FIFO: captures dirty victim lines and drains them as write beats.
// Optional feature macro EVICTBUF_SNOOP_EN adds {tag,set} snoop comparators on held entries.
module cache_evict_buffer #(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned SETLEN  = 9,
    parameter int unsigned TAGLEN  = 20,
    parameter int unsigned LINELEN = 256,
    parameter int unsigned BEATLEN = 64,
    parameter int unsigned DEPTH   = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    cache_evict_buffer_if.slave evb
);
    localparam int unsigned OFFSETLEN = $clog2(LINELEN / 8);
    localparam int unsigned BEATS     = LINELEN / BEATLEN;
    localparam int unsigned PALEN     = TAGLEN + SETLEN + OFFSETLEN;
    localparam int unsigned BeatBytes = BEATLEN / 8;
    localparam int unsigned BeatW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW      = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [TAGLEN-1:0]               tag_mem  [DEPTH];
    logic [SETLEN-1:0]               set_mem  [DEPTH];
    logic [BEATS-1:0][BEATLEN-1:0]   line_mem [DEPTH];

    logic dirty;
    logic full;
    logic push;
    logic pop;
    logic last_beat;
    logic send;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Capture side: full comes from the registered count, so a same-cycle pop never unblocks a push.
    assign dirty = |(evb.VictimWay & evb.DirtyWay);
    assign full  = (count_q == CntW'(DEPTH));
    assign push  = evb.EvictReq & dirty & ~full;

    assign evb.EvictAccept = evb.EvictReq & (~dirty | ~full);
    assign evb.ClearDirty  = push ? evb.VictimWay : '0;
    assign evb.BufEmpty    = (count_q == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q]  <= evb.VictimTag;
            set_mem[wr_ptr_q]  <= evb.VictimSet;
            line_mem[wr_ptr_q] <= evb.VictimLine;
        end
    end

    assign last_beat = (beat_q == BeatW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        send    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StSend;
                    beat_d  = '0;
                end
            end
            StSend: begin
                send = 1'b1;
                if (evb.BusReady) begin
                    if (last_beat) begin
                        pop    = 1'b1;
                        beat_d = '0;
                        // Another line is waiting if the popped head was not alone or one arrives now.
                        state_d = ((count_q > CntW'(1)) || push) ? StSend : StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign evb.BusValid = send;
    assign evb.BusLast  = send & last_beat;
    assign evb.BusAdr   = {tag_mem[rd_ptr_q], set_mem[rd_ptr_q], {OFFSETLEN{1'b0}}}
                        + PALEN'(beat_q) * PALEN'(BeatBytes);
    assign evb.BusData  = line_mem[rd_ptr_q][beat_q];

`ifdef EVICTBUF_SNOOP_EN
    // Per-slot occupancy; a slot becomes visible to snoop only after its push edge.
    logic [DEPTH-1:0] held_q;
    logic             snoop_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q <= '0;
        end else begin
            if (pop) begin
                held_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                held_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        snoop_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (held_q[i] && ({tag_mem[i], set_mem[i]} == evb.SnoopAdr)) begin
                snoop_hit = 1'b1;
            end
        end
    end

    assign evb.SnoopHit = snoop_hit;
`else
    logic unused_snoop;
    assign unused_snoop = ^evb.SnoopAdr;
    assign evb.SnoopHit = 1'b0;
`endif

    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (evb.BusValid && !evb.BusReady) |=>
        (evb.BusValid && $stable(evb.BusAdr) && $stable(evb.BusData) && $stable(evb.BusLast)));

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CntW'(DEPTH));

    a_clear_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(evb.ClearDirty));

endmodule

// File: tb/tb_cache_evict_buffer.sv
// Randomized + directed bench for cache_evict_buffer against a queue-based line model.
// Build with EVICTBUF_SNOOP_EN defined to expect live snoop hits.
module tb_cache_evict_buffer;
    localparam int unsigned NUMWAYS = 4;
    localparam int unsigned SETLEN  = 9;
    localparam int unsigned TAGLEN  = 20;
    localparam int unsigned LINELEN = 256;
    localparam int unsigned BEATLEN = 64;
    localparam int unsigned DEPTH   = 2;
    localparam int          BEATS   = 4;
`ifdef EVICTBUF_SNOOP_EN
    localparam bit SnoopEn = 1'b1;
`else
    localparam bit SnoopEn = 1'b0;
`endif

    typedef struct packed {
        logic [19:0]  tag;
        logic [8:0]   set;
        logic [255:0] line;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_evict_buffer_if #(
        .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN), .LINELEN(LINELEN), .BEATLEN(BEATLEN)
    ) evb ();

    cache_evict_buffer #(
        .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN), .LINELEN(LINELEN),
        .BEATLEN(BEATLEN), .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .evb    (evb)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered list of held lines, plus whether the head is on the bus and which beat.
    ent_t q[$];
    bit   sending = 1'b0;
    int   beat = 0;
    bit   last_acc = 1'b1;

    always @(negedge clk) begin : cmp
        logic        dirty, full, acc, pushm, hit, popped;
        logic [3:0]  clr;
        logic [33:0] adr;
        logic [63:0] data;
        ent_t        e;
        if (!reset_n) begin
            q.delete();
            sending  = 1'b0;
            beat     = 0;
            last_acc = 1'b1;
            chk("rst_busvalid", 64'(evb.BusValid), 64'd0);
            chk("rst_buslast", 64'(evb.BusLast), 64'd0);
            chk("rst_bufempty", 64'(evb.BufEmpty), 64'd1);
            chk("rst_snoophit", 64'(evb.SnoopHit), 64'd0);
        end else begin
            dirty = |(evb.VictimWay & evb.DirtyWay);
            full  = (q.size() == DEPTH);
            acc   = evb.EvictReq && (!dirty || !full);
            pushm = evb.EvictReq && dirty && !full;
            clr   = pushm ? evb.VictimWay : 4'b0;
            hit   = 1'b0;
            if (SnoopEn) begin
                foreach (q[i]) if ({q[i].tag, q[i].set} == evb.SnoopAdr) hit = 1'b1;
            end
            chk("evict_accept", 64'(evb.EvictAccept), 64'(acc));
            chk("clear_dirty", 64'(evb.ClearDirty), 64'(clr));
            chk("buf_empty", 64'(evb.BufEmpty), 64'(q.size() == 0));
            chk("bus_valid", 64'(evb.BusValid), 64'(sending));
            chk("snoop_hit", 64'(evb.SnoopHit), 64'(hit));
            if (sending) begin
                adr  = {q[0].tag, q[0].set, 5'b0} + 34'(beat * 8);
                data = q[0].line[beat*64 +: 64];
                chk("bus_adr", 64'(evb.BusAdr), 64'(adr));
                chk("bus_data", evb.BusData, data);
                chk("bus_last", 64'(evb.BusLast), 64'(beat == BEATS - 1));
            end
            last_acc = acc;
            popped   = 1'b0;
            if (!sending) begin
                if (q.size() != 0) begin
                    sending = 1'b1;
                    beat    = 0;
                end
            end else if (evb.BusReady) begin
                beat++;
                if (beat == BEATS) begin
                    void'(q.pop_front());
                    beat   = 0;
                    popped = 1'b1;
                end
            end
            if (pushm) begin
                e.tag  = evb.VictimTag;
                e.set  = evb.VictimSet;
                e.line = evb.VictimLine;
                q.push_back(e);
            end
            if (popped) sending = (q.size() != 0);
        end
    end

    task automatic drive_victim(input logic [3:0] way, input logic [3:0] dw,
                                input logic [19:0] tag, input logic [8:0] set,
                                input logic [255:0] line);
        evb.EvictReq   = 1'b1;
        evb.VictimWay  = way;
        evb.DirtyWay   = dw;
        evb.VictimTag  = tag;
        evb.VictimSet  = set;
        evb.VictimLine = line;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [33:0]  t2_adr [4];
        logic [255:0] kline;
        int           hs, last_hs, acc_cyc, gaps, seen_valid;
        logic [2:0]   rdy_pat;
        t2_adr = '{34'h48D154A0, 34'h48D154A8, 34'h48D154B0, 34'h48D154B8};
        kline  = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        rdy_pat = 3'b001;

        evb.EvictReq = 1'b0; evb.VictimWay = '0; evb.DirtyWay = '0; evb.VictimTag = '0;
        evb.VictimSet = '0; evb.VictimLine = '0; evb.BusReady = 1'b0; evb.SnoopAdr = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Single dirty evict with snoop on its own address.
        evb.BusReady = 1'b1;
        evb.SnoopAdr = {20'h12345, 9'h0A5};
        drive_victim(4'b0010, 4'b0010, 20'h12345, 9'h0A5, kline);
        @(negedge clk);
        chk("t2_accept", 64'(evb.EvictAccept), 64'd1);
        chk("t2_clear", 64'(evb.ClearDirty), 64'h2);
        chk("t2_snoop_push", 64'(evb.SnoopHit), 64'd0);
        tick();
        evb.EvictReq = 1'b0;
        @(negedge clk);
        chk("t2_idle_gap", 64'(evb.BusValid), 64'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("t2_valid", 64'(evb.BusValid), 64'd1);
            chk("t2_adr", 64'(evb.BusAdr), 64'(t2_adr[b]));
            chk("t2_data", evb.BusData, 64'hD0 + 64'(b));
            chk("t2_last", 64'(evb.BusLast), 64'(b == 3));
            chk("t2_snoop", 64'(evb.SnoopHit), 64'(SnoopEn));
        end
        @(negedge clk);
        chk("t2_empty", 64'(evb.BufEmpty), 64'd1);
        chk("t2_done_valid", 64'(evb.BusValid), 64'd0);
        chk("t2_snoop_after", 64'(evb.SnoopHit), 64'd0);
        tick();

        // Clean victim.
        drive_victim(4'b0100, 4'b1011, 20'h0BEEF, 9'h011, kline);
        @(negedge clk);
        chk("t3_accept", 64'(evb.EvictAccept), 64'd1);
        chk("t3_clear", 64'(evb.ClearDirty), 64'd0);
        tick();
        evb.EvictReq = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_no_valid", 64'(evb.BusValid), 64'd0);
        end
        tick();

        // Reset in the middle of beat 2.
        drive_victim(4'b0001, 4'b0001, 20'h12345, 9'h0A5, kline);
        tick();
        evb.EvictReq = 1'b0;
        repeat (3) tick();
        chk("t1_pre_valid", 64'(evb.BusValid), 64'd1);
        chk("t1_pre_adr", 64'(evb.BusAdr), 64'(t2_adr[2]));
        reset_n = 1'b0;
        #1;
        chk("t1_valid_drop", 64'(evb.BusValid), 64'd0);
        chk("t1_empty", 64'(evb.BufEmpty), 64'd1);
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_stay_idle", 64'(evb.BusValid), 64'd0);
        end
        tick();

        // Full stall: three dirty evicts with the bus blocked.
        evb.BusReady = 1'b0;
        drive_victim(4'b0001, 4'b1111, 20'h00A01, 9'h001, {8{32'hA1A1_0000}});
        tick();
        drive_victim(4'b0010, 4'b1111, 20'h00A02, 9'h002, {8{32'hA2A2_0000}});
        tick();
        drive_victim(4'b1000, 4'b1111, 20'h00A03, 9'h003, {8{32'hA3A3_0000}});
        @(negedge clk);
        chk("t4_third_blocked", 64'(evb.EvictAccept), 64'd0);
        tick();
        evb.BusReady = 1'b1;
        hs = 0; last_hs = -10; acc_cyc = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (evb.BusValid && evb.BusReady) hs++;
            if (evb.EvictAccept && evb.EvictReq && acc_cyc < 0) acc_cyc = c;
            if (evb.BusValid && evb.BusReady && evb.BusLast && last_hs < 0) last_hs = c;
            if (acc_cyc >= 0 && !evb.EvictReq && evb.BufEmpty) break;
            tick();
            if (acc_cyc >= 0) evb.EvictReq = 1'b0;
        end
        chk("t4_accept_timing", 64'(acc_cyc), 64'(last_hs + 1));
        chk("t4_total_beats", 64'(hs), 64'd12);
        tick();

        // Backpressure 1,0,0 with two queued lines.
        hs = 0; gaps = 0; seen_valid = 0;
        drive_victim(4'b0100, 4'b0100, 20'h00B01, 9'h0B1, {8{32'hB1B1_0000}});
        evb.BusReady = rdy_pat[0];
        tick();
        drive_victim(4'b0100, 4'b0100, 20'h00B02, 9'h0B2, {8{32'hB2B2_0000}});
        evb.BusReady = rdy_pat[1];
        for (int c = 2; c < 100; c++) begin
            @(negedge clk);
            if (evb.BusValid) seen_valid = 1;
            else if (seen_valid != 0 && hs < 8) gaps++;
            if (evb.BusValid && evb.BusReady) hs++;
            if (hs == 8) break;
            tick();
            evb.EvictReq = 1'b0;
            evb.BusReady = rdy_pat[c % 3];
        end
        chk("t5_beats", 64'(hs), 64'd8);
        chk("t5_no_gap", 64'(gaps), 64'd0);
        tick();

        // Randomized traffic with a mid-run reset pulse.
        for (int c = 0; c < 3000; c++) begin
            evb.BusReady = ($urandom_range(0, 99) < 60);
            evb.SnoopAdr = {20'h12340 + 20'($urandom_range(0, 3)), 9'h0A0 + 9'($urandom_range(0, 1))};
            if (!(evb.EvictReq && !last_acc)) begin
                if ($urandom_range(0, 99) < 35) begin
                    drive_victim(4'b0001 << $urandom_range(0, 3), 4'($urandom_range(0, 15)),
                                 20'h12340 + 20'($urandom_range(0, 3)),
                                 9'h0A0 + 9'($urandom_range(0, 1)),
                                 {$urandom(), $urandom(), $urandom(), $urandom(),
                                  $urandom(), $urandom(), $urandom(), $urandom()});
                end else begin
                    evb.EvictReq = 1'b0;
                end
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
            tick();
        end
        evb.EvictReq = 1'b0;
        evb.BusReady = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
